// File: rtl/fused_pkg.sv
// Shared types and requantization helper for the fused-layer OFM write-back path.
// Optional build macro: OFM_WB_RELU_EN clamps negative requantized lanes to zero.
package fused_pkg;

  localparam int unsigned NUM_PE         = 4;
  localparam int unsigned ACC_W          = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_STEP      = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } wb_state_t;

  // Arithmetic shift, saturate to int8, optionally clamp negatives to zero.
  function automatic logic [7:0] requant8(input logic signed [ACC_W-1:0] acc,
                                          input logic [4:0]              shift);
    logic signed [ACC_W-1:0] y;
    logic [7:0]              q;
    y = acc >>> shift;
    if (y > 127) begin
      q = 8'h7F;
    end else if (y < -128) begin
      q = 8'h80;
    end else begin
      q = y[7:0];
    end
`ifdef OFM_WB_RELU_EN
    if (y < 0) begin
      q = 8'h00;
    end
`endif
    return q;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO for packed OFM words; reset clears the pointers only.
module wb_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ofm_writeback_ctrl.sv
// OFM write-back: requantize PE beats to int8, pack, buffer and write to global BRAM.
// Optional build macro: OFM_WB_RELU_EN (ReLU clamp after saturation).
module ofm_writeback_ctrl
  import fused_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr_OFM,
  input  logic [15:0]             num_words,
  input  logic [4:0]              shift_amt,
  input  logic                    pe_valid,
  input  logic [NUM_PE*ACC_W-1:0] pe_data,
  output logic                    pe_ready,
  input  logic                    wr_grant,
  output logic [ADDR_W-1:0]       wr_addr_global,
  output logic [WORD_W-1:0]       wr_data_global,
  output logic                    we_global,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  wb_state_t         state, state_next;
  logic [15:0]       cfg_num_words, accepted, written;
  logic [4:0]        cfg_shift;
  logic [ADDR_W-1:0] wr_ptr_addr;
  logic              stage_valid;
  logic [WORD_W-1:0] stage_data, pack_c, fifo_head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              start_job, accept, wr_fire, bypass;

  // Requant stage plus FIFO together hold FIFO_DEPTH+1 words before back-pressure.
  assign pe_ready  = (state == RUN)
                   && ((SUM_W'(fifo_count) + SUM_W'(stage_valid)) <= SUM_W'(FIFO_DEPTH))
                   && (accepted < cfg_num_words);
  assign start_job = (state == IDLE) && start;
  assign accept    = pe_valid && pe_ready;
  assign wr_fire   = (!fifo_empty || stage_valid) && wr_grant;
  assign bypass    = wr_fire && fifo_empty;
  assign fifo_pop  = wr_fire && !fifo_empty;
  assign fifo_push = stage_valid && !bypass && (!fifo_full || fifo_pop);

  // Requantize all lanes of the incoming beat into one packed word.
  always_comb begin
    pack_c = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      pack_c[8*i +: 8] = requant8(pe_data[ACC_W*i +: ACC_W], cfg_shift);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (num_words == 16'd0) ? FIN : RUN;
      RUN:   if (accept && ((accepted + 16'd1) == cfg_num_words)) state_next = DRAIN;
      DRAIN: if (wr_fire && ((written + 16'd1) == cfg_num_words)) state_next = FIN;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Job configuration, beat/word counters and write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_num_words <= '0;
      cfg_shift     <= '0;
      wr_ptr_addr   <= '0;
      accepted      <= '0;
      written       <= '0;
    end else if (start_job) begin
      cfg_num_words <= num_words;
      cfg_shift     <= shift_amt;
      wr_ptr_addr   <= base_addr_OFM;
      accepted      <= '0;
      written       <= '0;
    end else begin
      if (accept) accepted <= accepted + 16'd1;
      if (wr_fire) begin
        written     <= written + 16'd1;
        wr_ptr_addr <= wr_ptr_addr + ADDR_W'(ADDR_STEP);
      end
    end
  end

  // Requant output register; drains into the FIFO or straight to the port when the FIFO is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else if (accept) begin
      stage_valid <= 1'b1;
      stage_data  <= pack_c;
    end else if (fifo_push || bypass) begin
      stage_valid <= 1'b0;
    end
  end

  wb_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (stage_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Global write port; address and data hold when no write is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_global      <= 1'b0;
      wr_addr_global <= '0;
      wr_data_global <= '0;
    end else begin
      we_global <= wr_fire;
      if (wr_fire) begin
        wr_addr_global <= wr_ptr_addr;
        wr_data_global <= fifo_empty ? stage_data : fifo_head;
      end
    end
  end

  // Status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == FIN);
      if (start_job) begin
        overflow_err <= 1'b0;
      end else if ((state == RUN) && pe_valid && !pe_ready && (accepted < cfg_num_words)) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ofm_writeback_ctrl.sv
// Scoreboard bench for ofm_writeback_ctrl: directed jobs, monitor checks every write.
module tb_ofm_writeback_ctrl;

  logic         clk = 1'b0;
  logic         reset_n, start, pe_valid, pe_ready, wr_grant;
  logic         we_global, busy, done, overflow_err;
  logic [31:0]  base_addr_OFM, wr_addr_global, wr_data_global;
  logic [15:0]  num_words;
  logic [4:0]   shift_amt;
  logic [127:0] pe_data;

  ofm_writeback_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr_OFM  (base_addr_OFM),
    .num_words      (num_words),
    .shift_amt      (shift_amt),
    .pe_valid       (pe_valid),
    .pe_data        (pe_data),
    .pe_ready       (pe_ready),
    .wr_grant       (wr_grant),
    .wr_addr_global (wr_addr_global),
    .wr_data_global (wr_data_global),
    .we_global      (we_global),
    .busy           (busy),
    .done           (done),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [127:0] tbl_data[$];
  logic [31:0]  tbl_word[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int we_total = 0, we_mark = 0, first_we_cyc = -1;
  int done_total = 0, done_cyc = -1;
  bit done_flag = 1'b0;
  int beat_idx = 0, job_n = 0, acc_cnt = 0, first_acc_cyc = -1, last_acc_cyc = -1, start_cyc = 0;
  logic [31:0] job_base = '0;
  wr_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write is compared against the next expected entry.
  always @(negedge clk) begin
    if (reset_n && we_global) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", wr_addr_global, wr_data_global);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", wr_addr_global, mon_e.addr);
        chk("wr_data", wr_data_global, mon_e.data);
      end
      if (we_total == we_mark) first_we_cyc = cyc;
      we_total++;
    end
    if (reset_n && done) begin
      done_total++;
      done_cyc  = cyc;
      done_flag = 1'b1;
    end
  end

  task automatic drive_beat();
    pe_valid = (beat_idx < job_n);
    pe_data  = (beat_idx < job_n) ? tbl_data[beat_idx] : '0;
  endtask

  // One clock: record an acceptance (and its expected write), then drive the next beat.
  task automatic step();
    wr_t e;
    @(negedge clk);
    if (pe_valid && pe_ready) begin
      e.addr = job_base + 32'(4 * beat_idx);
      e.data = tbl_word[beat_idx];
      exp_q.push_back(e);
      if (acc_cnt == 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
      acc_cnt++;
      beat_idx++;
    end
    @(posedge clk);
    #1;
    drive_beat();
  endtask

  task automatic start_job(input logic [31:0] base, input int n, input logic [4:0] sh);
    job_base      = base;
    job_n         = n;
    beat_idx      = 0;
    acc_cnt       = 0;
    we_mark       = we_total;
    first_we_cyc  = -1;
    done_flag     = 1'b0;
    start         = 1'b1;
    base_addr_OFM = base;
    num_words     = 16'(n);
    shift_amt     = sh;
    start_cyc     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive_beat();
  endtask

  task automatic wait_done(input int budget, input string name);
    int g = 0;
    while (!done_flag && g < budget) begin
      step();
      g++;
    end
    if (!done_flag) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: done not seen within %0d cycles, expected a done pulse", name, budget);
    end
  endtask

  // Lanes 4k..4k+3 with shift 0 pack to bytes 4k..4k+3.
  task automatic load_stream(input int n);
    logic [127:0] d;
    logic [31:0]  w;
    tbl_data.delete();
    tbl_word.delete();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        d[32*i +: 32] = 32'(4 * k + i);
        w[8*i +: 8]   = 8'(4 * k + i);
      end
      tbl_data.push_back(d);
      tbl_word.push_back(w);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},       32'(we_global),    32'd0);
    chk({tag, "_addr"},     wr_addr_global,    32'd0);
    chk({tag, "_data"},     wr_data_global,    32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_done"},     32'(done),         32'd0);
    chk({tag, "_overflow"}, 32'(overflow_err), 32'd0);
    chk({tag, "_pe_ready"}, 32'(pe_ready),     32'd0);
  endtask

  initial begin
    int g;
    int dmark;
    bit pulsed;
    reset_n = 1'b0; start = 1'b0; base_addr_OFM = '0; num_words = '0; shift_amt = '0;
    pe_valid = 1'b0; pe_data = '0; wr_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Requant and pack: shift 4, lanes 0x100, 0x7FFF, -300, 0.
    tbl_data.delete(); tbl_word.delete();
    tbl_data.push_back({32'h0000_0000, 32'hFFFF_FED4, 32'h0000_7FFF, 32'h0000_0100});
`ifdef OFM_WB_RELU_EN
    tbl_word.push_back(32'h0000_7F10);
`else
    tbl_word.push_back(32'h00ED_7F10);
`endif
    wr_grant = 1'b1;
    start_job(32'h0000_1000, 1, 5'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(20, "t1_done");
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Saturation corners at shift 0.
    tbl_data.delete(); tbl_word.delete();
    tbl_data.push_back({32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF7F, 32'h0000_00C8});
    tbl_data.push_back({32'hFFFF_FF80, 32'h0000_0080, 32'h7FFF_FFFF, 32'h8000_0000});
`ifdef OFM_WB_RELU_EN
    tbl_word.push_back(32'h7F00_007F);
    tbl_word.push_back(32'h007F_7F00);
`else
    tbl_word.push_back(32'h7FFF_807F);
    tbl_word.push_back(32'h807F_7F80);
`endif
    start_job(32'h0000_1100, 2, 5'd0);
    wait_done(20, "t2_done");
    chk("t2_writes", 32'(we_total - we_mark), 32'd2);

    // Streaming 8 words, with an ignored start pulse during RUN.
    load_stream(8);
    dmark = done_total;
    start_job(32'h0000_1000, 8, 5'd0);
    pulsed = 1'b0;
    g = 0;
    while (acc_cnt < 8 && g < 40) begin
      if (acc_cnt == 3 && !pulsed) begin
        start = 1'b1; num_words = 16'd0; base_addr_OFM = 32'h0000_9000; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      g++;
    end
    start = 1'b0;
    chk("t3_accepts", 32'(acc_cnt), 32'd8);
    wait_done(20, "t3_done");
    chk("t3_latency", 32'(first_we_cyc - first_acc_cyc), 32'd2);
    chk("t3_done_lat", 32'(done_cyc - last_acc_cyc), 32'd2);
    chk("t3_writes", 32'(we_total - we_mark), 32'd8);
    chk("t3_done_pulses", 32'(done_total - dmark), 32'd1);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure and overflow.
    load_stream(6);
    wr_grant = 1'b0;
    start_job(32'h0000_3000, 6, 5'd0);
    repeat (10) step();
    chk("t4_accepts", 32'(acc_cnt), 32'd5);
    chk("t4_pe_ready", 32'(pe_ready), 32'd0);
    chk("t4_overflow", 32'(overflow_err), 32'd1);
    chk("t4_no_writes", 32'(we_total - we_mark), 32'd0);
    wr_grant = 1'b1;
    wait_done(30, "t4_done");
    chk("t4_writes", 32'(we_total - we_mark), 32'd6);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_overflow_sticky", 32'(overflow_err), 32'd1);

    // Zero-length job clears overflow and pulses done without writes.
    tbl_data.delete(); tbl_word.delete();
    dmark = done_total;
    start_job(32'h0000_5000, 0, 5'd0);
    chk("t5_overflow_clr", 32'(overflow_err), 32'd0);
    wait_done(5, "t5_done");
    chk("t5_done_lat", 32'(done_cyc - start_cyc), 32'd1);
    chk("t5_no_writes", 32'(we_total - we_mark), 32'd0);
    chk("t5_done_pulses", 32'(done_total - dmark), 32'd1);

    // pe_valid in IDLE is ignored.
    pe_valid = 1'b1;
    pe_data  = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_overflow", 32'(overflow_err), 32'd0);
    chk("t6_idle_ready", 32'(pe_ready), 32'd0);
    pe_valid = 1'b0;

    // Reset mid-job, then a fresh job at 0x2000.
    load_stream(8);
    start_job(32'h0000_4000, 8, 5'd0);
    g = 0;
    while ((we_total - we_mark) < 3 && g < 30) begin
      step();
      g++;
    end
    chk("t7_pre_writes", 32'((we_total - we_mark) >= 3), 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero("t7_midreset");
    exp_q.delete();
    job_n = 0;
    beat_idx = 0;
    pe_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    load_stream(2);
    start_job(32'h0000_2000, 2, 5'd0);
    wait_done(20, "t7_done");
    chk("t7_writes", 32'(we_total - we_mark), 32'd2);
    chk("t7_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
